// File: rtl/ct_vfalu_pipe6_issue_wb_if.sv
// Issue/EX1/EX3/writeback signal bundle between the pipe6 issue block and its environment.
interface ct_vfalu_pipe6_issue_wb_if #(parameter int PREG_W = 7);
  // issue queue side
  logic              iq_pipe6_vld;
  logic              pipe6_iq_rdy;
  logic [19:0]       iq_pipe6_func;
  logic [2:0]        iq_pipe6_sel;
  logic [2:0]        iq_pipe6_imm0;
  logic [63:0]       iq_pipe6_srcf0;
  logic [63:0]       iq_pipe6_srcf1;
  logic [63:0]       iq_pipe6_mtvr_src0;
  logic              iq_pipe6_mfvr;
  logic [PREG_W-1:0] iq_pipe6_preg;
  // EX1 operand bus to the VFALU
  logic [19:0]       dp_vfalu_ex1_pipex_func;
  logic [2:0]        dp_vfalu_ex1_pipex_sel;
  logic [2:0]        dp_vfalu_ex1_pipex_imm0;
  logic [63:0]       dp_vfalu_ex1_pipex_srcf0;
  logic [63:0]       dp_vfalu_ex1_pipex_srcf1;
  logic [63:0]       dp_vfalu_ex1_pipex_mtvr_src0;
  // results from the VFALU
  logic [63:0]       pipex_dp_ex1_vfalu_mfvr_data;
  logic [63:0]       pipex_dp_ex3_vfalu_freg_data;
  logic [4:0]        pipex_dp_ex3_vfalu_ereg_data;
  // writeback
  logic              pipe6_wb_vld;
  logic              pipe6_wb_rdy;
  logic [PREG_W-1:0] pipe6_wb_preg;
  logic              pipe6_wb_mfvr;
  logic [63:0]       pipe6_wb_data;
  logic [4:0]        pipe6_wb_fflags;

  // environment side (issue queue, VFALU, writeback consumer)
  modport master (
    output iq_pipe6_vld, iq_pipe6_func, iq_pipe6_sel, iq_pipe6_imm0, iq_pipe6_srcf0,
           iq_pipe6_srcf1, iq_pipe6_mtvr_src0, iq_pipe6_mfvr, iq_pipe6_preg,
           pipex_dp_ex1_vfalu_mfvr_data, pipex_dp_ex3_vfalu_freg_data,
           pipex_dp_ex3_vfalu_ereg_data, pipe6_wb_rdy,
    input  pipe6_iq_rdy, dp_vfalu_ex1_pipex_func, dp_vfalu_ex1_pipex_sel,
           dp_vfalu_ex1_pipex_imm0, dp_vfalu_ex1_pipex_srcf0, dp_vfalu_ex1_pipex_srcf1,
           dp_vfalu_ex1_pipex_mtvr_src0, pipe6_wb_vld, pipe6_wb_preg, pipe6_wb_mfvr,
           pipe6_wb_data, pipe6_wb_fflags
  );

  // issue block side
  modport slave (
    input  iq_pipe6_vld, iq_pipe6_func, iq_pipe6_sel, iq_pipe6_imm0, iq_pipe6_srcf0,
           iq_pipe6_srcf1, iq_pipe6_mtvr_src0, iq_pipe6_mfvr, iq_pipe6_preg,
           pipex_dp_ex1_vfalu_mfvr_data, pipex_dp_ex3_vfalu_freg_data,
           pipex_dp_ex3_vfalu_ereg_data, pipe6_wb_rdy,
    output pipe6_iq_rdy, dp_vfalu_ex1_pipex_func, dp_vfalu_ex1_pipex_sel,
           dp_vfalu_ex1_pipex_imm0, dp_vfalu_ex1_pipex_srcf0, dp_vfalu_ex1_pipex_srcf1,
           dp_vfalu_ex1_pipex_mtvr_src0, pipe6_wb_vld, pipe6_wb_preg, pipe6_wb_mfvr,
           pipe6_wb_data, pipe6_wb_fflags
  );
endinterface

// File: rtl/ct_vfalu_pipe6_issue_wb.sv
// Pipe6 VFALU issue/writeback: EX1 operand register, EX1..EX3 op tracker,
// credit-protected in-order writeback FIFO with dual push (EX3 freg + EX1 mfvr).
module ct_vfalu_pipe6_issue_wb #(
  parameter int WB_DEPTH = 4,
  parameter int PREG_W   = 7
) (
  input logic                     forever_cpuclk,
  input logic                     cpurst_b,
  input logic                     rtu_yy_xx_flush,
  ct_vfalu_pipe6_issue_wb_if.slave bus
);
  localparam int CW = $clog2(WB_DEPTH + 1);
  localparam int AW = $clog2(WB_DEPTH);

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic              mfvr;
    logic [63:0]       data;
    logic [4:0]        fflags;
  } wb_ent_t;

  // pointer = {wrap, index}; index wraps at WB_DEPTH so non power-of-two depths work
  function automatic logic [AW:0] f_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(WB_DEPTH - 1)) f_inc = {~p[AW], {AW{1'b0}}};
    else                                f_inc = {p[AW], p[AW-1:0] + AW'(1)};
  endfunction

  logic [CW-1:0]     r_credit;
  logic              r_ex1_vld, r_ex1_mfvr, r_ex2_vld, r_ex3_vld;
  logic [PREG_W-1:0] r_ex1_preg, r_ex2_preg, r_ex3_preg;
  logic [19:0]       r_ex1_func;
  logic [2:0]        r_ex1_sel, r_ex1_imm0;
  logic [63:0]       r_ex1_srcf0, r_ex1_srcf1, r_ex1_mtvr;
  logic [AW:0]       r_wptr, r_rptr;
  wb_ent_t           r_mem [WB_DEPTH];

  logic              w_acc, w_pop, w_empty, w_push_f, w_push_m;
  logic [AW:0]       w_wptr1;
  wb_ent_t           w_ent_f, w_ent_m, w_head;

  assign w_empty  = (r_rptr == r_wptr);
  assign w_acc    = bus.iq_pipe6_vld & (r_credit != '0) & ~rtu_yy_xx_flush;
  assign w_pop    = ~w_empty & bus.pipe6_wb_rdy & ~rtu_yy_xx_flush;
  assign w_push_f = r_ex3_vld;
  assign w_push_m = r_ex1_vld & r_ex1_mfvr;
  assign w_wptr1  = f_inc(r_wptr);
  assign w_ent_f  = '{preg: r_ex3_preg, mfvr: 1'b0,
                      data: bus.pipex_dp_ex3_vfalu_freg_data,
                      fflags: bus.pipex_dp_ex3_vfalu_ereg_data};
  assign w_ent_m  = '{preg: r_ex1_preg, mfvr: 1'b1,
                      data: bus.pipex_dp_ex1_vfalu_mfvr_data, fflags: 5'd0};
  assign w_head   = r_mem[r_rptr[AW-1:0]];

  assign bus.pipe6_iq_rdy                 = (r_credit != '0);
  assign bus.dp_vfalu_ex1_pipex_sel       = r_ex1_vld ? r_ex1_sel : 3'b0;
  assign bus.dp_vfalu_ex1_pipex_func      = r_ex1_func;
  assign bus.dp_vfalu_ex1_pipex_imm0      = r_ex1_imm0;
  assign bus.dp_vfalu_ex1_pipex_srcf0     = r_ex1_srcf0;
  assign bus.dp_vfalu_ex1_pipex_srcf1     = r_ex1_srcf1;
  assign bus.dp_vfalu_ex1_pipex_mtvr_src0 = r_ex1_mtvr;
  assign bus.pipe6_wb_vld                 = ~w_empty;
  assign bus.pipe6_wb_preg                = w_head.preg;
  assign bus.pipe6_wb_mfvr                = w_head.mfvr;
  assign bus.pipe6_wb_data                = w_head.data;
  assign bus.pipe6_wb_fflags              = w_head.fflags;

  // credit: one slot reserved per accepted op, returned on pop
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b || rtu_yy_xx_flush) r_credit <= CW'(WB_DEPTH);
    else begin
      case ({w_acc, w_pop})
        2'b10:   r_credit <= r_credit - CW'(1);
        2'b01:   r_credit <= r_credit + CW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  // EX1 operand register; fields hold when idle so the bus does not toggle
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_ex1_vld <= 1'b0; r_ex1_mfvr <= 1'b0; r_ex1_preg <= '0;
      r_ex1_func <= '0; r_ex1_sel <= '0; r_ex1_imm0 <= '0;
      r_ex1_srcf0 <= '0; r_ex1_srcf1 <= '0; r_ex1_mtvr <= '0;
    end else begin
      r_ex1_vld <= w_acc;
      if (w_acc) begin
        r_ex1_mfvr  <= bus.iq_pipe6_mfvr;   r_ex1_preg  <= bus.iq_pipe6_preg;
        r_ex1_func  <= bus.iq_pipe6_func;   r_ex1_sel   <= bus.iq_pipe6_sel;
        r_ex1_imm0  <= bus.iq_pipe6_imm0;   r_ex1_srcf0 <= bus.iq_pipe6_srcf0;
        r_ex1_srcf1 <= bus.iq_pipe6_srcf1;  r_ex1_mtvr  <= bus.iq_pipe6_mtvr_src0;
      end
    end
  end

  // EX2/EX3 tracker; mfvr ops already retired in EX1 so only freg ops advance
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b || rtu_yy_xx_flush) begin
      r_ex2_vld <= 1'b0; r_ex3_vld <= 1'b0; r_ex2_preg <= '0; r_ex3_preg <= '0;
    end else begin
      r_ex2_vld  <= r_ex1_vld & ~r_ex1_mfvr;
      r_ex3_vld  <= r_ex2_vld;
      r_ex2_preg <= r_ex1_preg;
      r_ex3_preg <= r_ex2_preg;
    end
  end

  // FIFO storage; on a dual push the older EX3 result takes the first slot
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      for (int i = 0; i < WB_DEPTH; i++) r_mem[i] <= '0;
    end else if (!rtu_yy_xx_flush) begin
      if (w_push_f) r_mem[r_wptr[AW-1:0]] <= w_ent_f;
      if (w_push_m) r_mem[w_push_f ? w_wptr1[AW-1:0] : r_wptr[AW-1:0]] <= w_ent_m;
    end
  end

  // FIFO pointers: write advances by 0/1/2, read by 0/1
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b || rtu_yy_xx_flush) begin
      r_wptr <= '0; r_rptr <= '0;
    end else begin
      if (w_push_f && w_push_m)      r_wptr <= f_inc(w_wptr1);
      else if (w_push_f || w_push_m) r_wptr <= w_wptr1;
      if (w_pop)                     r_rptr <= f_inc(r_rptr);
    end
  end
endmodule

// File: tb/tb_ct_vfalu_pipe6_issue_wb.sv
// Bench for ct_vfalu_pipe6_issue_wb: VFALU stub plus a queue-based reference of
// in-flight ops (completion cycle per op) and buffered results.
module tb_ct_vfalu_pipe6_issue_wb;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  ct_vfalu_pipe6_issue_wb_if #(.PREG_W(7)) bus ();
  ct_vfalu_pipe6_issue_wb #(.WB_DEPTH(DEPTH), .PREG_W(7)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .rtu_yy_xx_flush(flush), .bus(bus));

  // VFALU stub: mfvr result combinational in EX1, freg result/flags two cycles later
  logic [63:0] st2_d, st3_d;
  logic [4:0]  st2_f, st3_f;
  assign bus.pipex_dp_ex1_vfalu_mfvr_data = bus.dp_vfalu_ex1_pipex_mtvr_src0 ^ bus.dp_vfalu_ex1_pipex_srcf1;
  always @(posedge clk) begin
    st2_d <= bus.dp_vfalu_ex1_pipex_srcf0 + bus.dp_vfalu_ex1_pipex_srcf1;
    st2_f <= bus.dp_vfalu_ex1_pipex_func[4:0];
    st3_d <= st2_d;
    st3_f <= st2_f;
  end
  assign bus.pipex_dp_ex3_vfalu_freg_data = st3_d;
  assign bus.pipex_dp_ex3_vfalu_ereg_data = st3_f;

  typedef struct {
    int          done;
    logic        mf;
    logic [6:0]  preg;
    logic [63:0] data;
    logic [4:0]  ff;
  } op_t;

  op_t  pend[$], fq[$];
  int   cyc = 0, vecs = 0, miscompares = 0;
  bit   last_acc, ex1_vld_m;
  logic [2:0] ex1_sel_m, ex1_imm_m;
  logic [19:0] ex1_func_m;
  logic [63:0] ex1_a_m, ex1_b_m, ex1_g_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic mf, input logic [6:0] preg, input logic [19:0] func,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] g);
    bus.iq_pipe6_mfvr = mf;  bus.iq_pipe6_preg = preg; bus.iq_pipe6_func = func;
    bus.iq_pipe6_srcf0 = a;  bus.iq_pipe6_srcf1 = b;   bus.iq_pipe6_mtvr_src0 = g;
    bus.iq_pipe6_sel = 3'b001 << $urandom_range(0, 2);
    bus.iq_pipe6_imm0 = 3'($urandom);
  endtask

  task automatic rand_op(input int mf_pct);
    set_op(($urandom_range(0, 99) < mf_pct), 7'($urandom), 20'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic check_all();
    chk("iq_rdy", bus.pipe6_iq_rdy, 64'((pend.size() + fq.size()) < DEPTH));
    chk("wb_vld", bus.pipe6_wb_vld, 64'(fq.size() != 0));
    if (fq.size() != 0) begin
      chk("wb_preg",   bus.pipe6_wb_preg,   fq[0].preg);
      chk("wb_mfvr",   bus.pipe6_wb_mfvr,   fq[0].mf);
      chk("wb_data",   bus.pipe6_wb_data,   fq[0].data);
      chk("wb_fflags", bus.pipe6_wb_fflags, fq[0].ff);
    end
    chk("ex1_sel", bus.dp_vfalu_ex1_pipex_sel, ex1_vld_m ? ex1_sel_m : 3'b0);
    if (ex1_vld_m) begin
      chk("ex1_func",  bus.dp_vfalu_ex1_pipex_func,  ex1_func_m);
      chk("ex1_imm0",  bus.dp_vfalu_ex1_pipex_imm0,  ex1_imm_m);
      chk("ex1_srcf0", bus.dp_vfalu_ex1_pipex_srcf0, ex1_a_m);
      chk("ex1_srcf1", bus.dp_vfalu_ex1_pipex_srcf1, ex1_b_m);
      chk("ex1_mtvr",  bus.dp_vfalu_ex1_pipex_mtvr_src0, ex1_g_m);
    end
  endtask

  // one clock: drive inputs, advance the reference across the edge, then check
  task automatic tick(input bit fl, input bit v, input bit rdy);
    op_t o, keep[$];
    bit  rdy_m;
    flush = fl; bus.iq_pipe6_vld = v; bus.pipe6_wb_rdy = rdy;
    rdy_m = (pend.size() + fq.size()) < DEPTH;
    last_acc = 1'b0;
    if (fl || !rst_n) begin
      pend.delete(); fq.delete(); ex1_vld_m = 1'b0;
    end else begin
      if (fq.size() != 0 && rdy) void'(fq.pop_front());
      last_acc = v && rdy_m;
      ex1_vld_m = last_acc;
      if (last_acc) begin
        ex1_sel_m = bus.iq_pipe6_sel;   ex1_func_m = bus.iq_pipe6_func;
        ex1_imm_m = bus.iq_pipe6_imm0;  ex1_a_m = bus.iq_pipe6_srcf0;
        ex1_b_m = bus.iq_pipe6_srcf1;   ex1_g_m = bus.iq_pipe6_mtvr_src0;
        o.mf   = bus.iq_pipe6_mfvr;
        o.preg = bus.iq_pipe6_preg;
        o.done = cyc + (o.mf ? 1 : 3);
        o.data = o.mf ? (bus.iq_pipe6_mtvr_src0 ^ bus.iq_pipe6_srcf1)
                      : (bus.iq_pipe6_srcf0 + bus.iq_pipe6_srcf1);
        o.ff   = o.mf ? 5'd0 : bus.iq_pipe6_func[4:0];
        pend.push_back(o);
      end
    end
    @(posedge clk); cyc++; @(negedge clk);
    // results completed last cycle are now buffered; older (freg) first on a tie
    foreach (pend[i]) if (pend[i].done == cyc - 1 && !pend[i].mf) fq.push_back(pend[i]);
    foreach (pend[i]) if (pend[i].done == cyc - 1 &&  pend[i].mf) fq.push_back(pend[i]);
    foreach (pend[i]) if (pend[i].done != cyc - 1) keep.push_back(pend[i]);
    pend = keep;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_iq_rdy"}, bus.pipe6_iq_rdy, 64'd1);
    chk({tag, "_wb_vld"}, bus.pipe6_wb_vld, 64'd0);
    chk({tag, "_wb_preg"}, bus.pipe6_wb_preg, 64'd0);
    chk({tag, "_wb_mfvr"}, bus.pipe6_wb_mfvr, 64'd0);
    chk({tag, "_wb_data"}, bus.pipe6_wb_data, 64'd0);
    chk({tag, "_wb_fflags"}, bus.pipe6_wb_fflags, 64'd0);
    chk({tag, "_ex1_func"}, bus.dp_vfalu_ex1_pipex_func, 64'd0);
    chk({tag, "_ex1_srcf0"}, bus.dp_vfalu_ex1_pipex_srcf0, 64'd0);
    chk({tag, "_ex1_mtvr"}, bus.dp_vfalu_ex1_pipex_mtvr_src0, 64'd0);
  endtask

  initial begin
    int n, accs;
    bus.iq_pipe6_vld = 1'b0; bus.pipe6_wb_rdy = 1'b0;
    set_op(1'b0, 7'd0, 20'd0, 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    // reset state
    tick(0, 0, 0); tick(0, 0, 0);
    rst_n = 1'b1;
    check_zero("rst");
    tick(0, 0, 1);

    // single freg op, latency 4
    set_op(1'b0, 7'd5, 20'h00013, 64'h3FF0000000000000, 64'h4000000000000000, 64'd0);
    tick(0, 1, 1);
    n = 1;
    while (!bus.pipe6_wb_vld && n < 10) begin tick(0, 0, 1); n++; end
    chk("lat_freg", n, 4);
    chk("freg_preg", bus.pipe6_wb_preg, 7'd5);
    chk("freg_data", bus.pipe6_wb_data, 64'h7FF0000000000000);
    tick(0, 0, 1);

    // single mfvr op, latency 2
    set_op(1'b1, 7'd9, 20'h0001F, 64'd1, 64'h00FF, 64'hFF00);
    tick(0, 1, 1);
    n = 1;
    while (!bus.pipe6_wb_vld && n < 10) begin tick(0, 0, 1); n++; end
    chk("lat_mfvr", n, 2);
    for (int i = 0; i < 3; i++) tick(0, 0, 1);

    // dual push: freg at T, mfvr at T+2, both complete in T+3
    set_op(1'b0, 7'd20, 20'h00007, 64'd100, 64'd23, 64'd0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    set_op(1'b1, 7'd21, 20'h00007, 64'd0, 64'h1234, 64'h1000);
    tick(0, 1, 0);
    tick(0, 0, 0);
    chk("dual_cnt", fq.size(), 2);
    chk("dual_first_mfvr", bus.pipe6_wb_mfvr, 1'b0);
    tick(0, 0, 1);
    chk("dual_second_mfvr", bus.pipe6_wb_mfvr, 1'b1);
    chk("dual_second_ff", bus.pipe6_wb_fflags, 5'd0);
    tick(0, 0, 1);

    // credit exhaustion with wb_rdy=0, then a single pop frees one slot
    accs = 0;
    for (int i = 0; i < 8; i++) begin rand_op(50); tick(0, 1, 0); accs += int'(last_acc); end
    chk("credit_accepts", accs, DEPTH);
    chk("credit_rdy0", bus.pipe6_iq_rdy, 1'b0);
    tick(0, 1, 1);
    chk("pop_acc_blocked", last_acc, 1'b0);
    rand_op(50); tick(0, 1, 0);
    chk("pop_acc_one", last_acc, 1'b1);
    tick(0, 1, 0);
    chk("pop_acc_none", last_acc, 1'b0);
    for (int i = 0; i < 8; i++) tick(0, 0, 1);

    // flush with 1 buffered and 3 in flight
    set_op(1'b0, 7'd1, 20'd1, 64'd1, 64'd1, 64'd0);
    tick(0, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    for (int i = 0; i < 3; i++) begin rand_op(0); tick(0, 1, 0); end
    tick(1, 1, 1);
    chk("flush_wb_vld", bus.pipe6_wb_vld, 1'b0);
    chk("flush_iq_rdy", bus.pipe6_iq_rdy, 1'b1);
    chk("flush_sel", bus.dp_vfalu_ex1_pipex_sel, 3'b0);
    for (int i = 0; i < 6; i++) tick(0, 0, 1);

    // back-to-back 20 ops, wb_rdy=1
    for (int i = 0; i < 20; i++) begin rand_op(40); tick(0, 1, 1); end
    for (int i = 0; i < 6; i++) tick(0, 0, 1);

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      rand_op(40);
      tick(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60));
    end

    // reset while full
    for (int i = 0; i < 8; i++) begin rand_op(30); tick(0, 1, 0); end
    chk("full_rdy0", bus.pipe6_iq_rdy, 1'b0);
    rst_n = 1'b0;
    tick(0, 0, 0);
    rst_n = 1'b1;
    check_zero("rst_full");
    tick(0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
